spi_master_core: RTL
====================

# spi_master_core

SPI master engine that executes one full-duplex SPI transaction per `start_in` request using the per-transaction configuration presented on the DIO control bus. It drives the external SCK/CS/MOSI pins and samples MISO. It reports completion through `busy_out` and `miso_data_out`. It sits between the AXI-side register/DIO control stage and the SPI pads.

## Interface
- No parameters; data path fixed at 32 bits.
- `CLK` in 1: system clock; all logic on rising edge.
- `RST` in 1: reset, synchronous, active-low.
- `start_in` in 1: transaction request, sampled only in IDLE.
- `spi_mode_in` in 2: [1]=CPOL, [0]=CPHA.
- `sck_speed_in` in 2: SCK half-period H = 2^(sck_speed_in+1) CLK cycles (2/4/8/16).
- `word_len_in` in 2: transaction length N = 8*(word_len_in+1) bits (8/16/24/32).
- `IFG_in` in 8: inter-frame gap g, in CLK cycles, CS high, busy still high.
- `CS_SCK_in` in 8: CS-fall to first SCK edge, c cycles (0 treated as 1).
- `SCK_CS_in` in 8: end of last SCK half-period to CS rise, s cycles (0 treated as 1).
- `mosi_data_in` in 32: transmit word; bits [N-1:0] used, MSB first.
- `MISO_in` in 1: serial input from slave.
- `SCK_out` out 1: serial clock.
- `CS_out` out 1: chip select, active-low.
- `MOSI_out` out 1: serial output.
- `busy_out` out 1: transaction in progress.
- `miso_data_out` out 32: received word, right-aligned, zero-extended.

## Operation
- FSM states: IDLE → CS_SETUP → TRANSFER → CS_HOLD → GAP → IDLE.
- IDLE with `start_in`=1:
  - Latch all config inputs and `mosi_data_in`.
  - Next state is CS_SETUP.
  - Inputs are not re-sampled until the next IDLE.
- `start_in` is ignored in every non-IDLE state; no queuing.
- CS_SETUP: `CS_out`=0; lasts max(c,1) cycles.
- TRANSFER: 2N half-periods of H cycles each. `SCK_out` toggles on the first cycle of every half-period, giving edges 1..2N. Odd edges are leading, even edges trailing.
- CPHA=0:
  - MOSI bit N-1 is driven on the CS_out fall cycle.
  - MISO is sampled on odd edges.
  - MOSI shifts to the next bit on even edges 2..2N-2.
- CPHA=1:
  - MOSI updates on odd edges; bit N-1 appears at edge 1.
  - MISO is sampled on even edges.
- SCK idles at latched CPOL. The idle level updates when config is latched on accept.
- CS_HOLD: starts after the 2N-th half-period completes; SCK at CPOL; lasts max(s,1) cycles.
- At CS_HOLD exit:
  - `CS_out`→1.
  - `MOSI_out`→0.
  - `miso_data_out` ← received N bits, zero-extended.
- GAP: lasts g cycles (g=0 allowed: skip straight to IDLE).
- `miso_data_out` holds its value until the next completed transaction.
- Reset values: `SCK_out`=0, `CS_out`=1, `MOSI_out`=0, `busy_out`=0, `miso_data_out`=0, latched CPOL=0, state IDLE.
- Reset asserted mid-transaction aborts it. All outputs take reset values on the next edge; no partial `miso_data_out` update.

## Timing
- All outputs are registered.
- `start_in` sampled at edge T:
  - `busy_out`=1 and `CS_out`=0 from cycle T+1.
  - First SCK edge at T+1+max(c,1).
- Busy duration D = max(c,1) + 2N·H + max(s,1) + g cycles. `busy_out` is high in cycles T+1..T+D.
- `CS_out` rises at cycle T+1+max(c,1)+2N·H+max(s,1). `miso_data_out` is valid the same cycle.
- The first cycle with `busy_out`=0 is IDLE. A `start_in` there is accepted, so CS is high for at least g+1 cycles between frames.
- MISO is sampled on the CLK edge at which SCK toggles. The bit must be stable in the preceding cycle.

## Test plan
- Mode 0, H=2, N=8, c=2, s=2, g=3, mosi=0xA5, MISO looped to MOSI → `miso_data_out`=0x000000A5; busy high 39 cycles; 16 SCK edges, SCK idle 0.
- Mode 3, sck_speed=1, N=32, mosi=0xDEADBEEF, loopback → SCK idles 1, 64 edges every 4 cycles, `miso_data_out`=0xDEADBEEF.
- Mode 1, N=16, mosi=0xFFFF1234, MISO tied 1 → MOSI carries 0x1234 MSB first; `miso_data_out`=0x0000FFFF.
- c=0, s=0, g=0, N=8, H=2, second start on first idle cycle → first SCK edge 1 cycle after CS fall; CS high exactly 1 cycle between frames; busy 34 cycles each.
- Start pulses and config/mosi changes during TRANSFER and GAP → ignored; the frame completes with the latched values.
- RST low for one cycle mid-TRANSFER → next cycle CS_out=1, SCK_out=0, MOSI_out=0, busy_out=0, miso_data_out=0. A subsequent start runs a clean frame.

Source files
------------

// File: rtl/spi_master_core.sv
// Single-transaction SPI master: latches per-frame config on start, runs CS setup, 2N SCK
// half-periods, CS hold and inter-frame gap, then publishes the received word.
module spi_master_core (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_in,
  input  logic [1:0]  spi_mode_in,
  input  logic [1:0]  sck_speed_in,
  input  logic [1:0]  word_len_in,
  input  logic [7:0]  IFG_in,
  input  logic [7:0]  CS_SCK_in,
  input  logic [7:0]  SCK_CS_in,
  input  logic [31:0] mosi_data_in,
  input  logic        MISO_in,
  output logic        SCK_out,
  output logic        CS_out,
  output logic        MOSI_out,
  output logic        busy_out,
  output logic [31:0] miso_data_out
);

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StTransfer,
    StCsHold,
    StGap
  } state_e;

  state_e      state_q, state_d;
  logic        cpol_q, cpol_d;
  logic        cpha_q, cpha_d;
  logic [1:0]  speed_q, speed_d;
  logic [1:0]  len_q, len_d;
  logic [7:0]  ifg_q, ifg_d;
  logic [7:0]  setup_q, setup_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [6:0]  edge_cnt_q, edge_cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rdata_q, rdata_d;
  logic        sck_q, sck_d;
  logic        cs_q, cs_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;

  logic [7:0]  setup_last, hold_last, ifg_last;
  logic [3:0]  half_last;
  logic [6:0]  edges_total, next_edge;
  logic [31:0] tx_aligned;
  logic        do_edge, sample_now, shift_now;

  // Zero setup/hold lengths still take one cycle.
  assign setup_last = (setup_q == 8'd0) ? 8'd0 : setup_q - 8'd1;
  assign hold_last  = (hold_q == 8'd0) ? 8'd0 : hold_q - 8'd1;
  assign ifg_last   = ifg_q - 8'd1;

  always_comb begin
    half_last = 4'd1;
    unique case (speed_q)
      2'd0: half_last = 4'd1;
      2'd1: half_last = 4'd3;
      2'd2: half_last = 4'd7;
      2'd3: half_last = 4'd15;
      default: half_last = 4'd1;
    endcase
  end

  // 2N edges = 16 * (word_len + 1)
  assign edges_total = {({1'b0, len_q} + 3'd1), 4'b0000};
  assign next_edge   = edge_cnt_q + 7'd1;

  // Odd edges sample for CPHA=0, even edges for CPHA=1.
  assign sample_now = next_edge[0] ^ cpha_q;
  assign shift_now  = cpha_q ? next_edge[0] : (!next_edge[0] && (next_edge != edges_total));

  // Transmit word is left-aligned so bit 31 is always the next bit out.
  always_comb begin
    tx_aligned = mosi_data_in;
    unique case (word_len_in)
      2'd0: tx_aligned = {mosi_data_in[7:0], 24'd0};
      2'd1: tx_aligned = {mosi_data_in[15:0], 16'd0};
      2'd2: tx_aligned = {mosi_data_in[23:0], 8'd0};
      2'd3: tx_aligned = mosi_data_in;
      default: tx_aligned = mosi_data_in;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    speed_d    = speed_q;
    len_d      = len_q;
    ifg_d      = ifg_q;
    setup_d    = setup_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rdata_d    = rdata_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    do_edge    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d    = StCsSetup;
          cpol_d     = spi_mode_in[1];
          cpha_d     = spi_mode_in[0];
          speed_d    = sck_speed_in;
          len_d      = word_len_in;
          ifg_d      = IFG_in;
          setup_d    = CS_SCK_in;
          hold_d     = SCK_CS_in;
          cnt_d      = 8'd0;
          edge_cnt_d = 7'd0;
          rx_d       = 32'd0;
          busy_d     = 1'b1;
          cs_d       = 1'b0;
          sck_d      = spi_mode_in[1];
          if (spi_mode_in[0]) begin
            tx_d   = tx_aligned;
            mosi_d = 1'b0;
          end else begin
            // CPHA=0 presents the MSB together with the CS fall.
            tx_d   = {tx_aligned[30:0], 1'b0};
            mosi_d = tx_aligned[31];
          end
        end
      end
      StCsSetup: begin
        if (cnt_q == setup_last) begin
          state_d = StTransfer;
          cnt_d   = 8'd0;
          do_edge = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StTransfer: begin
        if (cnt_q == {4'd0, half_last}) begin
          cnt_d = 8'd0;
          if (edge_cnt_q == edges_total) begin
            state_d = StCsHold;
          end else begin
            do_edge = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StCsHold: begin
        if (cnt_q == hold_last) begin
          cnt_d   = 8'd0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          rdata_d = rx_q;
          if (ifg_q == 8'd0) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StGap: begin
        if (cnt_q == ifg_last) begin
          cnt_d   = 8'd0;
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_edge) begin
      sck_d      = ~sck_q;
      edge_cnt_d = next_edge;
      if (sample_now) begin
        rx_d = {rx_q[30:0], MISO_in};
      end
      if (shift_now) begin
        mosi_d = tx_q[31];
        tx_d   = {tx_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StIdle;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      speed_q    <= 2'd0;
      len_q      <= 2'd0;
      ifg_q      <= 8'd0;
      setup_q    <= 8'd0;
      hold_q     <= 8'd0;
      cnt_q      <= 8'd0;
      edge_cnt_q <= 7'd0;
      tx_q       <= 32'd0;
      rx_q       <= 32'd0;
      rdata_q    <= 32'd0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      speed_q    <= speed_d;
      len_q      <= len_d;
      ifg_q      <= ifg_d;
      setup_q    <= setup_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rdata_q    <= rdata_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
    end
  end

  assign SCK_out       = sck_q;
  assign CS_out        = cs_q;
  assign MOSI_out      = mosi_q;
  assign busy_out      = busy_q;
  assign miso_data_out = rdata_q;

endmodule
